lcd_write_engine: RTL and testbench



---
 rtl/lcd_write_engine.sv | 174 +++++++++++++++++
 tb/tb_lcd_write_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_engine.sv
// HD44780 byte writer: queues {RS,byte} words (WR_READY low when FIFO full), then drives DB/RS/E setup/pulse/hold/wait.
// Word accepted at edge 0 is on LCD_DB after edge 1. Optional LCD_LONG_CMD_DETECT_EN: LONG_WAIT after clear/home.
module lcd_write_engine #(
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter logic [31:0] SETUP_CYCLES    = 32'd2,
    parameter logic [31:0] E_PULSE_CYCLES  = 32'd12,
    parameter logic [31:0] HOLD_CYCLES     = 32'd1,
    parameter logic [31:0] EXEC_WAIT       = 32'd2000,
    parameter logic [31:0] LONG_WAIT       = 32'd82000
) (
    input  logic                     CLK_50MHZ,
    input  logic                     RST_N,
    input  logic                     WR_VALID,
    output logic                     WR_READY,
    input  logic                     WR_RS,
    input  logic [7:0]               WR_DATA,
    output logic [7:0]               LCD_DB,
    output logic                     LCD_E,
    output logic                     LCD_RS,
    output logic                     LCD_RW,
    output logic                     BUSY,
    output logic [FIFO_DEPTH_LOG2:0] FIFO_COUNT
);
    localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] DEPTH_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

    // Counter reload values: a phase of N cycles loads N-1; zero is treated as one.
    localparam logic [31:0] SETUP_LD = (SETUP_CYCLES   == 32'd0) ? 32'd0 : SETUP_CYCLES   - 32'd1;
    localparam logic [31:0] PULSE_LD = (E_PULSE_CYCLES == 32'd0) ? 32'd0 : E_PULSE_CYCLES - 32'd1;
    localparam logic [31:0] HOLD_LD  = (HOLD_CYCLES    == 32'd0) ? 32'd0 : HOLD_CYCLES    - 32'd1;
    localparam logic [31:0] EXEC_LD  = (EXEC_WAIT      == 32'd0) ? 32'd0 : EXEC_WAIT      - 32'd1;
    localparam logic [31:0] LONG_LD  = (LONG_WAIT      == 32'd0) ? 32'd0 : LONG_WAIT      - 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    state_t                     state, state_next;
    logic [31:0]                cnt, cnt_next;
    logic                       e_next;
    logic                       busy_next;
    logic                       long_sel;
    logic                       head_long;
    logic                       push, pop;
    logic [8:0]                 mem [DEPTH];
    logic [8:0]                 head;
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count, count_next;

    assign WR_READY   = (count < DEPTH_CNT);
    assign push       = WR_VALID & WR_READY;
    assign head       = mem[rd_ptr];
    assign FIFO_COUNT = count;
    assign LCD_RW     = 1'b0;

`ifdef LCD_LONG_CMD_DETECT_EN
    assign head_long = ~head[8] && ((head[7:0] == 8'h01) || (head[7:0] == 8'h02) || (head[7:0] == 8'h03));
`else
    assign head_long = 1'b0;
`endif

    always_ff @(posedge CLK_50MHZ) begin
        if (push) begin
            mem[wr_ptr] <= {WR_RS, WR_DATA};
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Each phase loads its length minus one and advances when the counter hits zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        e_next     = LCD_E;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = ST_SETUP;
                    cnt_next   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (cnt == 32'd0) begin
                    e_next     = 1'b1;
                    state_next = ST_PULSE;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt - 32'd1;
                end
            end
            ST_PULSE: begin
                if (cnt == 32'd0) begin
                    e_next     = 1'b0;
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LD;
                end else begin
                    cnt_next = cnt - 32'd1;
                end
            end
            ST_HOLD: begin
                if (cnt == 32'd0) begin
                    state_next = ST_WAIT;
                    cnt_next   = long_sel ? LONG_LD : EXEC_LD;
                end else begin
                    cnt_next = cnt - 32'd1;
                end
            end
            ST_WAIT: begin
                if (cnt == 32'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - 32'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                e_next     = 1'b0;
            end
        endcase
        busy_next = (state_next != ST_IDLE) || (count_next != '0);
    end

    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            LCD_E    <= 1'b0;
            LCD_DB   <= '0;
            LCD_RS   <= 1'b0;
            long_sel <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            LCD_E <= e_next;
            BUSY  <= busy_next;
            if (pop) begin
                LCD_DB   <= head[7:0];
                LCD_RS   <= head[8];
                long_sel <= head_long;
            end
        end
    end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine: a default-timing instance and an all-zero-timing instance, checked every cycle against a schedule model.
`timescale 1ns/1ps
module tb_lcd_write_engine;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] wr_valid = 2'b00;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [1:0] wr_ready, lcd_e, lcd_rs, lcd_rw, busy;
    logic [7:0] lcd_db [2];
    logic [2:0] fifo_count [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_write_engine dut (
        .CLK_50MHZ(clk), .RST_N(rst_n), .WR_VALID(wr_valid[0]), .WR_READY(wr_ready[0]),
        .WR_RS(wr_rs), .WR_DATA(wr_data), .LCD_DB(lcd_db[0]), .LCD_E(lcd_e[0]),
        .LCD_RS(lcd_rs[0]), .LCD_RW(lcd_rw[0]), .BUSY(busy[0]), .FIFO_COUNT(fifo_count[0])
    );

    lcd_write_engine #(
        .FIFO_DEPTH_LOG2(2), .SETUP_CYCLES(32'd0), .E_PULSE_CYCLES(32'd0),
        .HOLD_CYCLES(32'd0), .EXEC_WAIT(32'd0), .LONG_WAIT(32'd0)
    ) dut_zero (
        .CLK_50MHZ(clk), .RST_N(rst_n), .WR_VALID(wr_valid[1]), .WR_READY(wr_ready[1]),
        .WR_RS(wr_rs), .WR_DATA(wr_data), .LCD_DB(lcd_db[1]), .LCD_E(lcd_e[1]),
        .LCD_RS(lcd_rs[1]), .LCD_RW(lcd_rw[1]), .BUSY(busy[1]), .FIFO_COUNT(fifo_count[1])
    );

    // Effective phase lengths per instance; the second instance has every parameter at 0, i.e. 1.
    int m_s [2] = '{2, 1};
    int m_p [2] = '{12, 1};
    int m_h [2] = '{1, 1};
    int m_w [2] = '{2000, 1};
    int m_l [2] = '{82000, 1};

    // Schedule model: queue of words, edge of the last pop, edge at which the engine is idle again.
    logic [8:0] m_list [2][256];
    int         m_head [2] = '{0, 0};
    int         m_tail [2] = '{0, 0};
    logic [8:0] m_cur  [2] = '{9'h000, 9'h000};
    int         m_tp   [2] = '{-1000000, -1000000};
    int         m_idle [2] = '{-1000, -1000};

    int   rises [2][64];
    int   nrise [2] = '{0, 0};
    int   ehigh [2] = '{0, 0};
    logic e_prev [2] = '{1'b0, 1'b0};

    function automatic int wait_for(input int i, input logic [8:0] w);
        logic long_cmd;
        long_cmd = 1'b0;
`ifdef LCD_LONG_CMD_DETECT_EN
        long_cmd = !w[8] && (w[7:0] >= 8'h01) && (w[7:0] <= 8'h03);
`endif
        return long_cmd ? m_l[i] : m_w[i];
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d at edge %0d: got 0x%0h, expected 0x%0h", nm, i, cyc, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_head[i] <= 0;
                m_tail[i] <= 0;
                m_cur[i]  <= 9'h000;
                m_tp[i]   <= -1000000;
                m_idle[i] <= -1000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if ((cyc >= m_idle[i]) && (m_tail[i] != m_head[i])) begin
                    m_cur[i]  <= m_list[i][m_head[i] % 256];
                    m_tp[i]   <= cyc + 1;
                    m_idle[i] <= cyc + 1 + m_s[i] + m_p[i] + m_h[i] + wait_for(i, m_list[i][m_head[i] % 256]);
                    m_head[i] <= m_head[i] + 1;
                end
                if (wr_valid[i] && ((m_tail[i] - m_head[i]) < 4)) begin
                    m_list[i][m_tail[i] % 256] <= {wr_rs, wr_data};
                    m_tail[i] <= m_tail[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_en) begin
                chk("lcd_db", i, 32'(lcd_db[i]), 32'(m_cur[i][7:0]));
                chk("lcd_rs", i, 32'(lcd_rs[i]), 32'(m_cur[i][8]));
                chk("lcd_rw", i, 32'(lcd_rw[i]), 32'd0);
                chk("lcd_e", i, 32'(lcd_e[i]),
                    32'((cyc >= m_tp[i] + m_s[i]) && (cyc < m_tp[i] + m_s[i] + m_p[i])));
                chk("busy", i, 32'(busy[i]), 32'((cyc < m_idle[i]) || (m_tail[i] != m_head[i])));
                chk("fifo_count", i, 32'(fifo_count[i]), 32'(m_tail[i] - m_head[i]));
                chk("wr_ready", i, 32'(wr_ready[i]), 32'((m_tail[i] - m_head[i]) < 4));
            end
            if (lcd_e[i] && !e_prev[i] && (nrise[i] < 64)) begin
                rises[i][nrise[i]] <= cyc;
                nrise[i] <= nrise[i] + 1;
            end
            if (lcd_e[i]) ehigh[i] <= ehigh[i] + 1;
            e_prev[i] <= lcd_e[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    task automatic push(input int i, input logic rs, input logic [7:0] d, output int acc);
        int   budget;
        logic took;
        budget = 0;
        took = 1'b0;
        wr_rs = rs;
        wr_data = d;
        wr_valid[i] = 1'b1;
        while (!took && (budget < 100000)) begin
            took = wr_ready[i];
            step();
            budget++;
        end
        wr_valid[i] = 1'b0;
        acc = cyc;
        if (!took) chk("push_timeout", i, 32'(wr_ready[i]), 32'd1);
    endtask

    task automatic push_at(input int i, input int edge_n, input logic rs, input logic [7:0] d);
        if (cyc > edge_n - 1) chk("push_at_late", i, 32'(cyc), 32'(edge_n - 1));
        wait_cyc(edge_n - 1);
        wr_rs = rs;
        wr_data = d;
        wr_valid[i] = 1'b1;
        step();
        wr_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int budget);
        int b;
        b = 0;
        while (busy[i] && (b < budget)) begin
            step();
            b++;
        end
        if (busy[i]) chk("idle_timeout", i, 32'(busy[i]), 32'd0);
    endtask

`ifdef LCD_LONG_CMD_DETECT_EN
    localparam int FILLS = 1;
    localparam int LONG_SPACING = 82016;
`else
    localparam int FILLS = 3;
    localparam int LONG_SPACING = 2016;
`endif

    initial begin
        int e, e2, r, hr;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_db", i, 32'(lcd_db[i]), 32'd0);
            chk("rst_e", i, 32'(lcd_e[i]), 32'd0);
            chk("rst_rs", i, 32'(lcd_rs[i]), 32'd0);
            chk("rst_count", i, 32'(fifo_count[i]), 32'd0);
            chk("rst_busy", i, 32'(busy[i]), 32'd0);
            chk("rst_ready", i, 32'(wr_ready[i]), 32'd1);
        end
        mon_en = 1'b1;
        rst_n = 1'b1;
        step();

        // Single command: timing pinned with literal edges.
        push(0, 1'b0, 8'h38, e);
        wait_cyc(e + 1);
        chk("t1_db", 0, 32'(lcd_db[0]), 32'h38);
        chk("t1_rs", 0, 32'(lcd_rs[0]), 32'd0);
        wait_cyc(e + 2);
        chk("t1_e_setup", 0, 32'(lcd_e[0]), 32'd0);
        wait_cyc(e + 3);
        chk("t1_e_rise", 0, 32'(lcd_e[0]), 32'd1);
        wait_cyc(e + 14);
        chk("t1_e_last", 0, 32'(lcd_e[0]), 32'd1);
        wait_cyc(e + 15);
        chk("t1_e_fall", 0, 32'(lcd_e[0]), 32'd0);
        wait_cyc(e + 2015);
        chk("t1_busy_wait", 0, 32'(busy[0]), 32'd1);
        wait_cyc(e + 2016);
        chk("t1_busy_idle", 0, 32'(busy[0]), 32'd0);
        step();

        // Fill the FIFO while the engine is busy; the fifth push is refused.
        for (int f = 0; f < FILLS; f++) begin
            r = nrise[0];
            push(0, 1'b1, 8'h50 + 8'(f * 8), e);
            wait_cyc(e + 3);
            for (int k = 0; k < 4; k++) push(0, k[0], 8'h51 + 8'(f * 8 + k), e2);
            chk("full_ready", 0, 32'(wr_ready[0]), 32'd0);
            chk("full_count", 0, 32'(fifo_count[0]), 32'd4);
            wr_rs = 1'b1;
            wr_data = 8'hEE;
            wr_valid[0] = 1'b1;
            step();
            wr_valid[0] = 1'b0;
            chk("full_refused", 0, 32'(fifo_count[0]), 32'd4);
            wait_idle(0, 12000);
            chk("fill_pulses", 0, 32'(nrise[0] - r), 32'd5);
        end
        step();

        // Push and pop on the same edge at count 2.
        push(0, 1'b0, 8'h0C, e);
        push(0, 1'b0, 8'h06, e2);
        push(0, 1'b1, 8'h43, e2);
        chk("pp_count_before", 0, 32'(fifo_count[0]), 32'd2);
        push_at(0, e + 2017, 1'b1, 8'h41);
        chk("pp_count_same", 0, 32'(fifo_count[0]), 32'd2);
        wait_cyc(e + 1 + 3 * 2016 + 3);
        chk("pp_e", 0, 32'(lcd_e[0]), 32'd1);
        chk("pp_rs", 0, 32'(lcd_rs[0]), 32'd1);
        chk("pp_db", 0, 32'(lcd_db[0]), 32'h41);
        wait_idle(0, 3000);
        step();

        // Clear display followed by entry mode: spacing depends on long-command detection.
        r = nrise[0];
        push(0, 1'b0, 8'h01, e);
        push(0, 1'b0, 8'h06, e2);
        wait_idle(0, 90000);
        chk("clr_rise", 0, 32'(rises[0][r]), 32'(e + 3));
        chk("clr_spacing", 0, 32'(rises[0][r + 1] - rises[0][r]), 32'(LONG_SPACING));
        step();

        // Reset during PULSE with one more word queued.
        push(0, 1'b0, 8'h80, e);
        push(0, 1'b1, 8'h20, e2);
        wait_cyc(e + 6);
        chk("rst_pre_e", 0, 32'(lcd_e[0]), 32'd1);
        chk("rst_pre_count", 0, 32'(fifo_count[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_e", 0, 32'(lcd_e[0]), 32'd0);
        chk("rst_mid_count", 0, 32'(fifo_count[0]), 32'd0);
        chk("rst_mid_busy", 0, 32'(busy[0]), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        r = nrise[0];
        repeat (2100) step();
        chk("rst_no_pulse", 0, 32'(nrise[0] - r), 32'd0);
        chk("rst_idle_busy", 0, 32'(busy[0]), 32'd0);
        chk("rst_idle_db", 0, 32'(lcd_db[0]), 32'd0);
        push(0, 1'b1, 8'h5A, e);
        wait_idle(0, 3000);
        chk("rst_new_pulse", 0, 32'(nrise[0] - r), 32'd1);
        step();

        // All-zero timing: every phase lasts one cycle.
        r = nrise[1];
        hr = ehigh[1];
        push(1, 1'b0, 8'h11, e);
        push(1, 1'b1, 8'h22, e2);
        wait_idle(1, 200);
        chk("zero_rise", 1, 32'(rises[1][r]), 32'(e + 2));
        chk("zero_spacing", 1, 32'(rises[1][r + 1] - rises[1][r]), 32'd5);
        chk("zero_e_width", 1, 32'(ehigh[1] - hr), 32'd2);
        chk("zero_db", 1, 32'(lcd_db[1]), 32'h22);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
